// File: rtl/spi_cmd_pkg.sv
// Shared types and SPI word field positions for the SPI command sequencer.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_WRITE = 3'b001,
        OP_READ  = 3'b010,
        OP_SET   = 3'b011,
        OP_CLR   = 3'b100
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_MODIFY,
        ST_WR_REQ
    } state_e;

    // Positions for the default 12-bit address / 16-bit data build
    localparam int TAG_BIT  = 31;
    localparam int OP_MSB   = 30;
    localparam int OP_LSB   = 28;
    localparam int ADDR_MSB = 27;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; head is the combinational oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spi_cmd_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI word -> register-bus sequencer (WRITE/READ/SET/CLR) with tag filter and per-phase timeout.
// Define SPI_CMD_CTRL_STATS_EN to add the cnt_exec / cnt_dup statistics outputs.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_ss,
    input  logic [31:0]       spi_din,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_tmo,
    input  logic              err_clr
`ifdef SPI_CMD_CTRL_STATS_EN
    ,
    output logic [7:0]        cnt_exec,
    output logic [7:0]        cnt_dup
`endif
);
    localparam int CMD_W = 3 + ADDR_W + DATA_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic ss_meta_q, ss_sync_q, ss_prev_q, cap_q;
    logic last_tag_q, last_tag_d;
    logic push, pop, dup, ovf_set, tmo_set, done;
    logic fifo_full, fifo_empty;
    logic [CMD_W-1:0] head;
    logic [2:0]       w_op;
    logic             w_valid_op;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mod_q, mod_d, rdata_q, rdata_d;
    logic              rvld_q, rvld_d, err_ovf_q, err_tmo_q;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              tmo_hit, counting;

    // SS is asynchronous; spi_din is taken the cycle after the synced rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_meta_q <= 1'b1;
            ss_sync_q <= 1'b1;
            ss_prev_q <= 1'b1;
            cap_q     <= 1'b0;
        end else begin
            ss_meta_q <= spi_ss;
            ss_sync_q <= ss_meta_q;
            ss_prev_q <= ss_sync_q;
            cap_q     <= ss_sync_q && !ss_prev_q;
        end
    end

    assign w_op       = spi_din[OP_MSB:OP_LSB];
    assign w_valid_op = (w_op == OP_WRITE) || (w_op == OP_READ) ||
                        (w_op == OP_SET)   || (w_op == OP_CLR);

    always_comb begin
        last_tag_d = last_tag_q;
        push       = 1'b0;
        dup        = 1'b0;
        ovf_set    = 1'b0;
        if (cap_q) begin
            if (spi_din[TAG_BIT] == last_tag_q)      dup = 1'b1;
            else if (!w_valid_op)                    last_tag_d = spi_din[TAG_BIT];
            else if (fifo_full && !pop)              ovf_set = 1'b1;
            else begin
                push       = 1'b1;
                last_tag_d = spi_din[TAG_BIT];
            end
        end
    end

    spi_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (spi_din[CMD_W-1:0]),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign counting = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_REQ);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mod_d   = mod_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        tmo_set = 1'b0;
        done    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                op_d    = head[CMD_W-1 -: 3];
                addr_d  = head[DATA_W +: ADDR_W];
                wdata_d = head[DATA_W-1:0];
                state_d = (head[CMD_W-1 -: 3] == OP_WRITE) ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (bus_gnt)      state_d = ST_RD_WAIT;
                else if (tmo_hit) begin tmo_set = 1'b1; state_d = ST_IDLE; end
            end
            ST_RD_WAIT: begin
                if (bus_rvalid) begin
                    if (op_q == OP_READ) begin
                        rdata_d = bus_rdata;
                        rvld_d  = 1'b1;
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        mod_d   = bus_rdata;
                        state_d = ST_MODIFY;
                    end
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            // wdata_q still holds the command operand here
            ST_MODIFY: begin
                wdata_d = (op_q == OP_SET) ? (mod_q | wdata_q) : (mod_q & ~wdata_q);
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (bus_gnt)      begin done = 1'b1; state_d = ST_IDLE; end
                else if (tmo_hit) begin tmo_set = 1'b1; state_d = ST_IDLE; end
            end
            default: state_d = ST_IDLE;
        endcase
        tmo_d = (state_d != state_q) ? '0 : (counting ? tmo_q + 1'b1 : tmo_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mod_q      <= '0;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
            tmo_q      <= '0;
            last_tag_q <= 1'b1;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mod_q      <= mod_d;
            rdata_q    <= rdata_d;
            rvld_q     <= rvld_d;
            tmo_q      <= tmo_d;
            last_tag_q <= last_tag_d;
            err_ovf_q  <= ovf_set ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
            err_tmo_q  <= tmo_set ? 1'b1 : (err_clr ? 1'b0 : err_tmo_q);
        end
    end

`ifdef SPI_CMD_CTRL_STATS_EN
    logic [7:0] cnt_exec_q, cnt_dup_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_exec_q <= '0;
            cnt_dup_q  <= '0;
        end else if (err_clr) begin
            cnt_exec_q <= '0;
            cnt_dup_q  <= '0;
        end else begin
            if (done && cnt_exec_q != 8'hFF) cnt_exec_q <= cnt_exec_q + 1'b1;
            if (dup  && cnt_dup_q  != 8'hFF) cnt_dup_q  <= cnt_dup_q + 1'b1;
        end
    end
    assign cnt_exec = cnt_exec_q;
    assign cnt_dup  = cnt_dup_q;
`endif

    assign bus_req     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign bus_we      = (state_q == ST_WR_REQ);
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvld_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign err_ovf     = err_ovf_q;
    assign err_tmo     = err_tmo_q;

endmodule
